// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states and default IMEM size.
package cpu_loader_pkg;
  localparam int IMEM_WORDS_DEF = 16384;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
  } ld_state_e;
endpackage

// File: rtl/cpu_instr_loader.sv
// Streams a length-prefixed byte image from a host into instruction memory,
// holding the CPU in reset until the image has been fully written.
module cpu_instr_loader
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] imem_addr,
  output logic        imem_wrt_en,
  output logic [31:0] imem_wrt_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  ld_state_e   state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] words_q, words_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] data_q, data_d;
  logic [15:0] addr_q, addr_d;
  logic        rdy_q, wr_q, hold_q, done_q, err_q;
  logic        acc;
  logic [15:0] len_full;

  assign acc      = in_valid && rdy_q;
  assign len_full = {in_data, count_q[7:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LEN_LO;
        words_d = '0;
        bcnt_d  = '0;
        addr_d  = '0;
      end
      S_LEN_LO: if (acc) begin
        count_d[7:0] = in_data;
        state_d      = S_LEN_HI;
      end
      S_LEN_HI: if (acc) begin
        count_d[15:8] = in_data;
        if (len_full == 16'd0)                          state_d = S_DONE;
        else if ({1'b0, len_full} > 17'(IMEM_WORDS))    state_d = S_ERR;
        else                                            state_d = S_DATA;
      end
      S_DATA: if (acc) begin
        // little-endian: the first byte ends up in [7:0] after four shifts
        data_d = {in_data, data_q[31:8]};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        if (words_q + 16'd1 == count_q) begin
          state_d = S_DONE;
        end else begin
          // only advance when another word follows, so 0xFFFC never wraps
          state_d = S_DATA;
          addr_d  = addr_q + 16'd4;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      words_q <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rdy_q   <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
      wr_q    <= (state_d == S_WRITE);
      hold_q  <= (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign in_ready      = rdy_q;
  assign imem_addr     = addr_q;
  assign imem_wrt_en   = wr_q;
  assign imem_wrt_data = data_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_cpu_instr_loader.sv
// Scoreboard bench for cpu_instr_loader: expected writes queued as bytes are
// driven, popped and compared whenever the loader strobes imem_wrt_en.
module tb_cpu_instr_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_wrt_en, cpu_hold, load_done, load_err;
  logic [15:0] imem_addr;
  logic [31:0] imem_wrt_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;
  logic [15:0] last_wr_addr;
  logic [47:0] exp_q[$];

  cpu_instr_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_addr(imem_addr), .imem_wrt_en(imem_wrt_en),
    .imem_wrt_data(imem_wrt_data), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_wrt_en) begin
      logic [47:0] e;
      n_wr++;
      last_wr_addr = imem_addr;
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e[47:32]));
        chk("wr_data", imem_wrt_data, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++guard > 100) begin
        chk("ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // sends one word, optionally with random stalls, and queues the expected write
  task automatic send_word(input logic [31:0] w, input logic [15:0] a, input bit gaps);
    exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) begin
      if (gaps && $urandom_range(0, 49) == 0)
        repeat ($urandom_range(1, 3)) @(posedge clk);
      #0 send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_wr = 0;
  endtask

  task automatic wait_end(input int limit);
    int c = 0;
    while (!(load_done || load_err)) begin
      @(negedge clk);
      if (++c > limit) begin
        chk("end_timeout", 32'(load_done), 32'd1);
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_wen",   32'(imem_wrt_en), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_data",  imem_wrt_data, 32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd1);
    chk("rst_done",  32'(load_done), 32'd0);
    chk("rst_err",   32'(load_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // basic two-word load
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h4433_2211, 16'h0000, 0);
    send_word(32'hDDCC_BBAA, 16'h0004, 0);
    wait_end(20);
    chk("basic_done", 32'(load_done), 32'd1);
    chk("basic_hold", 32'(cpu_hold), 32'd0);
    chk("basic_err",  32'(load_err), 32'd0);
    chk("basic_nwr",  32'(n_wr), 32'd2);

    // zero-length image
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);
    repeat (3) @(posedge clk);
    chk("zero_nwr", 32'(n_wr), 32'd0);

    // oversize image
    do_reset();
    pulse_start();
    send_byte(8'h01); send_byte(8'h40);
    @(negedge clk);
    chk("ovf_err",   32'(load_err), 32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_hold",  32'(cpu_hold), 32'd1);
    in_valid = 1'b1; in_data = 8'h5A;
    pulse_start();
    repeat (8) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_sticky", 32'(load_err), 32'd1);
    chk("ovf_done",   32'(load_done), 32'd0);
    chk("ovf_nwr",    32'(n_wr), 32'd0);

    // reset in the middle of word 3, then reload
    do_reset();
    pulse_start();
    send_byte(8'h05); send_byte(8'h00);
    send_word(32'h0302_0100, 16'h0000, 0);
    send_word(32'h0706_0504, 16'h0004, 0);
    send_byte(8'h08); send_byte(8'h09);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_wen",   32'(imem_wrt_en), 32'd0);
    chk("mid_addr",  32'(imem_addr), 32'd0);
    chk("mid_data",  imem_wrt_data, 32'd0);
    chk("mid_hold",  32'(cpu_hold), 32'd1);
    chk("mid_done",  32'(load_done), 32'd0);
    chk("mid_nwr",   32'(n_wr), 32'd2);
    do_reset();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'hCAFE_F00D, 16'h0000, 0);
    wait_end(20);
    chk("reload_done", 32'(load_done), 32'd1);
    chk("reload_nwr",  32'(n_wr), 32'd1);

    // start pulsed during DATA
    do_reset();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    exp_q.push_back({16'h0000, 32'h8765_4321});
    send_byte(8'h21); send_byte(8'h43);
    pulse_start();
    send_byte(8'h65); send_byte(8'h87);
    send_word(32'h1357_9BDF, 16'h0004, 0);
    wait_end(20);
    chk("st_done", 32'(load_done), 32'd1);
    chk("st_nwr",  32'(n_wr), 32'd2);

    // full-size image with random stalls
    do_reset();
    pulse_start();
    send_byte(8'h00); send_byte(8'h40);
    for (int i = 0; i < 16384; i++) begin
      w = $urandom();
      send_word(w, 16'(i * 4), 1);
    end
    wait_end(20);
    chk("full_done",  32'(load_done), 32'd1);
    chk("full_nwr",   32'(n_wr), 32'd16384);
    chk("full_last",  32'(last_wr_addr), 32'h0000_FFFC);
    chk("full_nowrap", 32'(imem_addr), 32'h0000_FFFC);
    chk("full_sb",    32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_instr_loader.md
CPU_INSTR_LOADER -- requirements
Module: cpu_instr_loader

Interface
REQ-001 The block SHALL have parameter IMEM_WORDS, default 16384, the instruction memory capacity in 32-bit words (64 KB).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, with reset synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle pulse that begins a load.
REQ-005 The block SHALL have port in_data, input, 8, the host byte stream.
REQ-006 The block SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-008 The block SHALL have port imem_addr, output, 16, the byte address to instruction memory.
REQ-009 The block SHALL have port imem_wrt_en, output, 1, the instruction memory write strobe.
REQ-010 The block SHALL have port imem_wrt_data, output, 32, the write word, with byte 0 at bits [7:0].
REQ-011 The block SHALL have port cpu_hold, output, 1, which holds the CPU in reset while high.
REQ-012 The block SHALL have port load_done, output, 1, level-high after a successful load.
REQ-013 The block SHALL have port load_err, output, 1, level-high after a rejected load.

Function
REQ-014 The block SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERR.
REQ-015 The block SHALL transfer a byte only in a cycle where in_valid and in_ready are both high.
REQ-016 in_ready SHALL be high only in LEN_LO, LEN_HI and DATA.
REQ-017 In IDLE, start SHALL move the block to LEN_LO; start SHALL be ignored in every other state.
REQ-018 LEN_LO SHALL capture word count bits [7:0]; LEN_HI SHALL capture bits [15:8].
REQ-019 After LEN_HI, the block SHALL go to DONE if count = 0, to ERR if count > IMEM_WORDS, and to DATA otherwise.
REQ-020 DATA SHALL pack 4 accepted bytes little-endian (first byte to [7:0]); the 4th byte SHALL move the block to WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with imem_wrt_en = 1 and imem_addr/imem_wrt_data stable; this write cycle is the cycle after the 4th byte is accepted.
REQ-022 imem_addr SHALL be 0x0000 for the first word and SHALL increment by 4 after each write.
REQ-023 After WRITE, the block SHALL go to DONE if words written = count, and to DATA otherwise.
REQ-024 A count of IMEM_WORDS SHALL write 0xFFFC last; the address SHALL NOT be written beyond 0xFFFC and SHALL NOT wrap to 0x0000.
REQ-025 imem_wrt_en SHALL be 0 in every state other than WRITE.
REQ-026 cpu_hold SHALL be 1 in every state except DONE.
REQ-027 DONE SHALL set load_done = 1; ERR SHALL set load_err = 1 with cpu_hold = 1; both states are sticky until rst.
REQ-028 Stalls (in_valid low) SHALL be allowed in any input state with unlimited length and SHALL not lose partial-word bytes.

Reset
REQ-029 On rst, the block SHALL enter IDLE with in_ready=0, imem_wrt_en=0, imem_addr=0, imem_wrt_data=0, cpu_hold=1, load_done=0, load_err=0, and clear the word/byte counters.
REQ-030 rst asserted mid-load SHALL abort the load with no further writes; memory contents already written are not cleared.

Structure
REQ-031 The state enum and IMEM_WORDS default SHALL reside in shared package cpu_loader_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the byte packer SHALL be inline shift/count logic.

Verification
REQ-033 The bench SHALL cover: start, bytes 02 00, 11 22 33 44, AA BB CC DD -> writes 0x44332211@0x0000 and 0xDDCCBBAA@0x0004, load_done=1, cpu_hold=0.
REQ-034 The bench SHALL cover: count 0x0000 -> no imem_wrt_en pulse; DONE the cycle after LEN_HI is accepted.
REQ-035 The bench SHALL cover: count 0x4001 -> load_err=1, in_ready=0, no writes, cpu_hold stays 1.
REQ-036 The bench SHALL cover: count 0x4000 with random in_valid gaps -> 16384 writes, last at 0xFFFC, data matches the reference model.
REQ-037 The bench SHALL cover: rst after 2 bytes of word 3 -> outputs at reset values next cycle; a new start reloads correctly from 0x0000.
REQ-038 The bench SHALL cover: start pulsed during DATA -> ignored, and byte order/addresses unaffected.
